// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and field constants for the data cache controller
package dcache_pkg;
    localparam int ADDR_W          = 16;
    localparam int WORD_W          = 16;
    localparam int INDEX_BITS_DEF  = 3;
    localparam int OFFSET_BITS_DEF = 2;
    localparam int LINE_WIDTH      = WORD_W << OFFSET_BITS_DEF;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WRITEBACK = 2'b01,
        ST_ALLOCATE  = 2'b10
    } state_t;
endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - tag/valid/dirty/data storage, synchronous write, asynchronous read
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS  = INDEX_BITS_DEF,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF,
    parameter int TAG_BITS    = ADDR_W - INDEX_BITS_DEF - OFFSET_BITS_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [INDEX_BITS-1:0]               index,
    input  logic                                fill,
    input  logic [TAG_BITS-1:0]                 fill_tag,
    input  logic [(WORD_W<<OFFSET_BITS)-1:0]    fill_data,
    input  logic                                wr,
    input  logic [OFFSET_BITS-1:0]              wr_offset,
    input  logic [WORD_W-1:0]                   wr_word,
    output logic [TAG_BITS-1:0]                 line_tag,
    output logic                                line_valid,
    output logic                                line_dirty,
    output logic [(WORD_W<<OFFSET_BITS)-1:0]    line_data
);
    localparam int LINES  = 1 << INDEX_BITS;
    localparam int LINE_W = WORD_W << OFFSET_BITS;

    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINE_W-1:0]   data_mem [LINES];
    logic [LINES-1:0]    valid_bits;
    logic [LINES-1:0]    dirty_bits;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill) begin
            valid_bits[index] <= 1'b1;
            dirty_bits[index] <= 1'b0;
        end else if (wr) begin
            dirty_bits[index] <= 1'b1;
        end
    end

    // Tags and data are not cleared, but a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (fill) begin
                tag_mem[index]  <= fill_tag;
                data_mem[index] <= fill_data;
            end else if (wr) begin
                data_mem[index][int'(wr_offset)*WORD_W +: WORD_W] <= wr_word;
            end
        end
    end

    assign line_tag   = tag_mem[index];
    assign line_valid = valid_bits[index];
    assign line_dirty = dirty_bits[index];
    assign line_data  = data_mem[index];
endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS  = INDEX_BITS_DEF,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                re,
    input  logic                                we,
    input  logic [ADDR_W-1:0]                   addr,
    input  logic [WORD_W-1:0]                   wrt_data,
    output logic [WORD_W-1:0]                   rd_data,
    output logic                                ready,
    output logic [ADDR_W-OFFSET_BITS-1:0]       mem_addr,
    output logic                                mem_re,
    output logic                                mem_we,
    output logic [(WORD_W<<OFFSET_BITS)-1:0]    mem_wdata,
    input  logic [(WORD_W<<OFFSET_BITS)-1:0]    mem_rdata,
    input  logic                                mem_rdy,
    output logic [15:0]                         hit_cnt,
    output logic [15:0]                         miss_cnt
);
    localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS;
    localparam int LINE_W   = WORD_W << OFFSET_BITS;

    state_t state, state_next;

    logic [OFFSET_BITS-1:0] offset;
    logic [INDEX_BITS-1:0]  index;
    logic [TAG_BITS-1:0]    tag;
    logic [TAG_BITS-1:0]    line_tag;
    logic                   line_valid, line_dirty;
    logic [LINE_W-1:0]      line_data;
    logic                   req, hit, fill, wr, hit_inc, miss_inc;

    assign offset = addr[OFFSET_BITS-1:0];
    assign index  = addr[OFFSET_BITS +: INDEX_BITS];
    assign tag    = addr[ADDR_W-1 -: TAG_BITS];
    assign req    = re | we;
    assign hit    = line_valid & (line_tag == tag);

    dcache_array #(
        .INDEX_BITS  (INDEX_BITS),
        .OFFSET_BITS (OFFSET_BITS),
        .TAG_BITS    (TAG_BITS)
    ) u_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .index      (index),
        .fill       (fill),
        .fill_tag   (tag),
        .fill_data  (mem_rdata),
        .wr         (wr),
        .wr_offset  (offset),
        .wr_word    (wrt_data),
        .line_tag   (line_tag),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_data  (line_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_next;
            if (hit_inc && hit_cnt != 16'hFFFF)
                hit_cnt <= hit_cnt + 16'd1;
            if (miss_inc && miss_cnt != 16'hFFFF)
                miss_cnt <= miss_cnt + 16'd1;
        end
    end

    // Store wins when re and we are both asserted; the stalled CPU re-presents the
    // request, so the post-fill IDLE cycle completes it as an ordinary hit.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        rd_data    = '0;
        fill       = 1'b0;
        wr         = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    if (hit) begin
                        hit_inc = 1'b1;
                        if (we)
                            wr = 1'b1;
                        else
                            rd_data = line_data[int'(offset)*WORD_W +: WORD_W];
                    end else begin
                        ready      = 1'b0;
                        miss_inc   = 1'b1;
                        state_next = (line_valid && line_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (mem_rdy)
                    state_next = ST_ALLOCATE;
            end
            ST_ALLOCATE: begin
                if (mem_rdy) begin
                    fill       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign mem_we    = (state == ST_WRITEBACK);
    assign mem_re    = (state == ST_ALLOCATE);
    assign mem_addr  = (state == ST_WRITEBACK) ? {line_tag, index} : {tag, index};
    assign mem_wdata = line_data;
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl against a line-level cache model
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, re, we;
    logic [15:0] addr, wrt_data, rd_data, hit_cnt, miss_cnt;
    logic        ready, mem_re, mem_we, mem_rdy, mem_rdy_r, spur;
    logic [13:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;

    int checks = 0;
    int passes = 0;
    int lat    = 4;
    int resp_cnt = 0;

    logic [63:0] mem [logic [13:0]];

    bit          m_valid [8];
    bit          m_dirty [8];
    logic [10:0] m_tag   [8];
    logic [63:0] m_line  [8];
    int          m_hit, m_miss;

    always #5 clk = ~clk;
    assign mem_rdy = mem_rdy_r | spur;

    dcache_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .re        (re),
        .we        (we),
        .addr      (addr),
        .wrt_data  (wrt_data),
        .rd_data   (rd_data),
        .ready     (ready),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    function automatic logic [63:0] fetch(input logic [13:0] la);
        if (!mem.exists(la))
            mem[la] = {$urandom, $urandom};
        return mem[la];
    endfunction

    // Main memory: completes a line transfer after lat cycles of mem_re/mem_we.
    always @(negedge clk) begin
        if (mem_re || mem_we) begin
            resp_cnt++;
            if (resp_cnt >= lat) begin
                resp_cnt  = 0;
                mem_rdy_r = 1'b1;
                if (mem_we)
                    mem[mem_addr] = mem_wdata;
                else
                    mem_rdata = fetch(mem_addr);
            end else begin
                mem_rdy_r = 1'b0;
            end
        end else begin
            resp_cnt  = 0;
            mem_rdy_r = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        m_hit  = 0;
        m_miss = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // kind: 0 load, 1 store, 2 load+store (treated as store)
    task automatic access(input logic [15:0] a, input int kind, input logic [15:0] d);
        logic [2:0]  idx;
        logic [10:0] tg;
        int          offi, cyc, wbn, ren, low;
        bit          wb, both;
        logic [63:0] fill_line, vline;
        logic [13:0] vaddr;
        idx  = a[4:2];
        tg   = a[15:5];
        offi = int'(a[1:0]);
        addr = a;
        re   = (kind != 1);
        we   = (kind != 0);
        wrt_data = d;
        #1;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            wb    = m_valid[idx] && m_dirty[idx];
            vaddr = {m_tag[idx], idx};
            vline = m_line[idx];
            m_miss = sat(m_miss + 1);
            fill_line = fetch({tg, idx});
            cyc = 0; wbn = 0; ren = 0; low = 0; both = 0;
            while (ready !== 1'b1 && cyc < 1000) begin
                low++;
                if (mem_re && mem_we) both = 1;
                if (mem_we) begin
                    if (wbn == 0) begin
                        check("wb_addr", 64'(mem_addr), 64'(vaddr));
                        check("wb_data", mem_wdata, vline);
                    end
                    wbn++;
                end
                if (mem_re) begin
                    if (ren == 0) check("alloc_addr", 64'(mem_addr), 64'({tg, idx}));
                    ren++;
                end
                step();
                cyc++;
            end
            check("miss_done", 64'(ready), 64'(1));
            check("wb_cycles", 64'(wbn), wb ? 64'(lat) : 64'(0));
            check("alloc_cycles", 64'(ren), 64'(lat));
            check("stall_cycles", 64'(low), 64'(1 + wbn + ren));
            check("re_we_excl", 64'(both), 64'(0));
            m_valid[idx] = 1;
            m_dirty[idx] = 0;
            m_tag[idx]   = tg;
            m_line[idx]  = fill_line;
        end
        check("hit_ready", 64'(ready), 64'(1));
        if (kind == 0) begin
            check("rd_data", 64'(rd_data), 64'(m_line[idx][offi*16 +: 16]));
        end else begin
            m_line[idx][offi*16 +: 16] = d;
            m_dirty[idx] = 1;
        end
        m_hit = sat(m_hit + 1);
        @(posedge clk);
        @(negedge clk);
        re = 0;
        we = 0;
        #1;
        check("hit_cnt", 64'(hit_cnt), 64'(m_hit));
        check("miss_cnt", 64'(miss_cnt), 64'(m_miss));
        check("idle_rd", 64'(rd_data), 64'(0));
        check("idle_mem", 64'({mem_re, mem_we}), 64'(0));
    endtask

    initial begin
        logic [63:0] lv;
        logic [15:0] ra;
        rst_n = 0; re = 0; we = 0; addr = 0; wrt_data = 0;
        spur = 0; mem_rdy_r = 0; mem_rdata = 0;
        model_reset();
        mem[14'h0010] = 64'h0004_0003_0002_0001;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_mem", 64'({mem_re, mem_we}), 64'(0));
        check("rst_cnt", 64'({hit_cnt, miss_cnt}), 64'(0));
        check("rst_rd", 64'(rd_data), 64'(0));

        lat = 4;
        access(16'h0040, 0, 16'h0);
        check("t1_rd_const", 64'(m_line[0][15:0]), 64'(16'h0001));
        access(16'h0041, 0, 16'h0);
        access(16'h0042, 0, 16'h0);
        access(16'h0043, 0, 16'h0);
        check("t2_hits", 64'(hit_cnt), 64'(4));

        access(16'h0042, 1, 16'hBEEF);
        access(16'h0142, 0, 16'h0);
        check("t3_wb_mem", mem[14'h0010], 64'h0004_BEEF_0002_0001);

        access(16'h0203, 2, 16'h1234);
        access(16'h0042, 0, 16'h0);
        lv = mem[14'h0080];
        check("t4_dirty_wb", 64'(lv[63:48]), 64'(16'h1234));

        // Abandon a fill mid-transfer with reset.
        addr = 16'h0104; re = 1; we = 0;
        #1;
        check("t5_miss", 64'(ready), 64'(0));
        step();
        step();
        check("t5_alloc", 64'(mem_re), 64'(1));
        rst_n = 0;
        re = 0;
        step();
        check("t5_mem_off", 64'({mem_re, mem_we}), 64'(0));
        check("t5_cnt", 64'({hit_cnt, miss_cnt}), 64'(0));
        check("t5_idle", 64'(ready), 64'(1));
        rst_n = 1;
        model_reset();
        access(16'h0104, 0, 16'h0);
        access(16'h0042, 0, 16'h0);

        access(16'hFFFF, 1, 16'hA5A5);
        access(16'hFFFF, 0, 16'h0);
        check("wrap_rd", 64'(m_line[7][63:48]), 64'(16'hA5A5));

        for (int i = 0; i < 250; i++) begin
            lat = $urandom_range(1, 5);
            ra  = {11'($urandom_range(0, 3)), 3'($urandom), 2'($urandom)};
            access(ra, $urandom_range(0, 2), 16'($urandom));
        end

        access(16'hFFFF, 0, 16'h0);
        addr = 16'hFFFF; re = 1; we = 0;
        for (int i = 0; i < 65540; i++) begin
            spur = (i == 100);
            @(posedge clk);
            @(negedge clk);
        end
        spur = 0;
        #1;
        check("sat_ready", 64'(ready), 64'(1));
        check("sat_rd", 64'(rd_data), 64'(m_line[7][63:48]));
        check("sat_mem", 64'({mem_re, mem_we}), 64'(0));
        m_hit = sat(m_hit + 65540);
        re = 0;
        step();
        check("sat_hit", 64'(hit_cnt), 64'(m_hit));
        check("sat_hit_max", 64'(hit_cnt), 64'(16'hFFFF));
        check("sat_miss", 64'(miss_cnt), 64'(m_miss));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
